// File: rtl/scorer_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : scorer_pkg
//  Description : Shared types and constants for the match scorer: controller
//                state encoding, winner codes, the active-low 7-segment digit
//                table and the status glyphs (dash, "L", "r").
//                Segment bit order is {g,f,e,d,c,b,a}; a 0 lights a segment.
//  Revision    : 1.0  initial release
// ============================================================================
package scorer_pkg;

    // Controller states: playing, showing a round winner, showing a match winner
    typedef enum logic [1:0] {
        ST_PLAY       = 2'd0,
        ST_ROUND_END  = 2'd1,
        ST_MATCH_DONE = 2'd2
    } state_t;

    // Winner codes as presented on the winner output (11 is never produced)
    localparam logic [1:0] c_winner_none  = 2'b00;
    localparam logic [1:0] c_winner_left  = 2'b01;
    localparam logic [1:0] c_winner_right = 2'b10;

    // Status glyphs, active-low {g,f,e,d,c,b,a}
    localparam logic [6:0] c_glyph_dash  = 7'b0111111;  // segment g only
    localparam logic [6:0] c_glyph_l     = 7'b1000111;  // segments d,e,f
    localparam logic [6:0] c_glyph_r     = 7'b0101111;  // segments e,g
    localparam logic [6:0] c_glyph_blank = 7'b1111111;

    // Digit-to-segment table; codes above 9 cannot occur as scores and blank
    localparam logic [6:0] c_seg_table [0:15] = '{
        7'b1000000,  // 0
        7'b1111001,  // 1
        7'b0100100,  // 2
        7'b0110000,  // 3
        7'b0011001,  // 4
        7'b0010010,  // 5
        7'b0000010,  // 6
        7'b1111000,  // 7
        7'b0000000,  // 8
        7'b0010000,  // 9
        c_glyph_blank,
        c_glyph_blank,
        c_glyph_blank,
        c_glyph_blank,
        c_glyph_blank,
        c_glyph_blank
    };

    // Table lookup wrapper so callers never index the constant array directly
    function automatic logic [6:0] seg7_lookup(input logic [3:0] digit);
        return c_seg_table[digit];
    endfunction

    // Status glyph for a winner code; anything other than left/right is a dash
    function automatic logic [6:0] status_glyph(input logic [1:0] win);
        logic [6:0] glyph;
        glyph = c_glyph_dash;
        if (win == c_winner_left) begin
            glyph = c_glyph_l;
        end else if (win == c_winner_right) begin
            glyph = c_glyph_r;
        end
        return glyph;
    endfunction

endpackage
`default_nettype wire

// File: rtl/seg7_decode.sv
`default_nettype none
// ============================================================================
//  Module      : seg7_decode
//  Description : Purely combinational 4-bit value to active-low 7-segment
//                pattern. Used once per player score.
//  Revision    : 1.0  initial release
// ============================================================================
module seg7_decode
    import scorer_pkg::*;
(
    input  logic [3:0] i_digit,
    output logic [6:0] o_seg
);

    assign o_seg = seg7_lookup(i_digit);

endmodule
`default_nettype wire

// File: rtl/match_scorer.sv
`default_nettype none
// ============================================================================
//  Module      : match_scorer
//  Description : Round / match referee for a two-player light game. Awards a
//                point when a player presses alone while the light sits at
//                their end, holds the playfield in reset for HOLD_CYCLES after
//                each round, and freezes on the match winner once a player
//                reaches WIN_ROUNDS points.
//                Build option: define MATCH_AUTO_RESTART_EN to let the match
//                result show for HOLD_CYCLES cycles and then start a fresh
//                match; otherwise the match result holds until rst.
//  Revision    : 1.0  initial release
// ============================================================================
module match_scorer
    import scorer_pkg::*;
#(
    parameter int WIN_ROUNDS  = 3,           // 1..9, fits the single digit display
    parameter int HOLD_CYCLES = 50_000_000   // >= 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       L,
    input  logic       R,
    input  logic       L_edge,
    input  logic       R_edge,
    output logic [6:0] hex_l,
    output logic [6:0] hex_r,
    output logic [6:0] hex_stat,
    output logic       play_rst,
    output logic       match_over,
    output logic [1:0] winner
);

    // Hold counter only has to represent HOLD_CYCLES-1 down to 0
    localparam int               c_hold_w    = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [c_hold_w-1:0] c_hold_load = c_hold_w'(HOLD_CYCLES - 1);
    localparam logic [c_hold_w-1:0] c_hold_one  = c_hold_w'(1);
    localparam logic [3:0]       c_win_score = 4'(WIN_ROUNDS);

    state_t              state_q,   state_d;
    logic [3:0]          score_l_q, score_l_d;
    logic [3:0]          score_r_q, score_r_d;
    logic [c_hold_w-1:0] hold_q,    hold_d;
    logic [1:0]          winner_q,  winner_d;

    logic                w_point_l;
    logic                w_point_r;
    logic [3:0]          w_score_l_inc;
    logic [3:0]          w_score_r_inc;

    // A press only counts when the light is at the presser's end and the
    // opponent is not pressing at the same time; pressing together is a wash.
    assign w_point_l     = L_edge & L & ~R;
    assign w_point_r     = R_edge & R & ~L;
    assign w_score_l_inc = score_l_q + 4'd1;
    assign w_score_r_inc = score_r_q + 4'd1;

    // State, score, hold and winner registers with synchronous reset taking priority
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_PLAY;
            score_l_q <= 4'd0;
            score_r_q <= 4'd0;
            hold_q    <= '0;
            winner_q  <= c_winner_none;
        end else begin
            state_q   <= state_d;
            score_l_q <= score_l_d;
            score_r_q <= score_r_d;
            hold_q    <= hold_d;
            winner_q  <= winner_d;
        end
    end

    // Next-state logic: score in PLAY, count the hold down in the end states
    always_comb begin
        state_d   = state_q;
        score_l_d = score_l_q;
        score_r_d = score_r_q;
        hold_d    = hold_q;
        winner_d  = winner_q;

        case (state_q)
            ST_PLAY: begin
                winner_d = c_winner_none;
                if (w_point_l) begin
                    score_l_d = w_score_l_inc;
                    winner_d  = c_winner_left;
                    hold_d    = c_hold_load;
                    state_d   = (w_score_l_inc == c_win_score) ? ST_MATCH_DONE
                                                               : ST_ROUND_END;
                end else if (w_point_r) begin
                    score_r_d = w_score_r_inc;
                    winner_d  = c_winner_right;
                    hold_d    = c_hold_load;
                    state_d   = (w_score_r_inc == c_win_score) ? ST_MATCH_DONE
                                                               : ST_ROUND_END;
                end
            end

            // Keys and edge lights are deliberately not looked at here
            ST_ROUND_END: begin
                if (hold_q == '0) begin
                    state_d  = ST_PLAY;
                    winner_d = c_winner_none;
                end else begin
                    hold_d = hold_q - c_hold_one;
                end
            end

            ST_MATCH_DONE: begin
`ifdef MATCH_AUTO_RESTART_EN
                // Show the match result for the same hold time, then start over
                if (hold_q == '0) begin
                    state_d   = ST_PLAY;
                    winner_d  = c_winner_none;
                    score_l_d = 4'd0;
                    score_r_d = 4'd0;
                end else begin
                    hold_d = hold_q - c_hold_one;
                end
`else
                // Match result stays on display until rst
                state_d = ST_MATCH_DONE;
`endif
            end

            default: begin
                state_d  = ST_PLAY;
                winner_d = c_winner_none;
            end
        endcase
    end

    // Status glyph decoded from the registered winner
    always_comb begin
        hex_stat = status_glyph(winner_q);
    end

    assign play_rst   = (state_q != ST_PLAY);
    assign match_over = (state_q == ST_MATCH_DONE);
    assign winner     = winner_q;

    seg7_decode u_seg_l (
        .i_digit (score_l_q),
        .o_seg   (hex_l)
    );

    seg7_decode u_seg_r (
        .i_digit (score_r_q),
        .o_seg   (hex_r)
    );

endmodule
`default_nettype wire

// File: tb/tb_match_scorer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_match_scorer
//  Description : Self-checking bench for match_scorer (WIN_ROUNDS=3,
//                HOLD_CYCLES=4). The reference keeps scores and the absolute
//                cycle at which play resumes; outputs are rebuilt from that.
//                Honours MATCH_AUTO_RESTART_EN when the RTL is built with it.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_match_scorer;

    localparam int WIN  = 3;
    localparam int HOLD = 4;

    localparam logic [6:0] DIG0 = 7'b1000000;
    localparam logic [6:0] DIG1 = 7'b1111001;
    localparam logic [6:0] DIG2 = 7'b0100100;
    localparam logic [6:0] DIG3 = 7'b0110000;
    localparam logic [6:0] DASH = 7'b0111111;
    localparam logic [6:0] GL   = 7'b1000111;
    localparam logic [6:0] GR   = 7'b0101111;

    logic       clk = 1'b0;
    logic       rst, L, R, L_edge, R_edge;
    logic [6:0] hex_l, hex_r, hex_stat;
    logic       play_rst, match_over;
    logic [1:0] winner;
    logic [24:0] dut_vec;

    int n_vec = 0;
    int n_bad = 0;

    // Reference model state
    int         m_k      = 0;   // index of the last clock edge applied
    int         m_sl     = 0;
    int         m_sr     = 0;
    logic [1:0] m_win    = 2'b00;
    bit         m_done   = 1'b0;
    int         m_resume = 0;   // first edge index after which play is live again
    bit         m_play   = 1'b1;

    match_scorer #(
        .WIN_ROUNDS  (WIN),
        .HOLD_CYCLES (HOLD)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .L          (L),
        .R          (R),
        .L_edge     (L_edge),
        .R_edge     (R_edge),
        .hex_l      (hex_l),
        .hex_r      (hex_r),
        .hex_stat   (hex_stat),
        .play_rst   (play_rst),
        .match_over (match_over),
        .winner     (winner)
    );

    always #5 clk = ~clk;

    assign dut_vec = {hex_l, hex_r, hex_stat, play_rst, match_over, winner};

    function automatic logic [6:0] digit_seg(input int d);
        case (d)
            0: return 7'b1000000;
            1: return 7'b1111001;
            2: return 7'b0100100;
            3: return 7'b0110000;
            4: return 7'b0011001;
            5: return 7'b0010010;
            6: return 7'b0000010;
            7: return 7'b1111000;
            8: return 7'b0000000;
            9: return 7'b0010000;
            default: return 7'b1111111;
        endcase
    endfunction

    function automatic logic [24:0] model_out();
        logic [1:0] w;
        logic [6:0] st;
        w  = m_play ? 2'b00 : m_win;
        st = (w == 2'b01) ? GL : (w == 2'b10) ? GR : DASH;
        return {digit_seg(m_sl), digit_seg(m_sr), st, ~m_play, m_done, w};
    endfunction

    // Advance the model by one clock edge using the inputs now applied, then
    // let the DUT take the same edge and settle before anything is sampled.
    task automatic tick();
        m_k++;
        if (rst) begin
            m_sl = 0; m_sr = 0; m_win = 2'b00; m_done = 1'b0; m_resume = 0;
        end else if (m_play) begin
            if (L && L_edge && !R) begin
                m_sl++; m_win = 2'b01; m_resume = m_k + HOLD; m_done = (m_sl == WIN);
            end else if (R && R_edge && !L) begin
                m_sr++; m_win = 2'b10; m_resume = m_k + HOLD; m_done = (m_sr == WIN);
            end
        end else if (m_done) begin
`ifdef MATCH_AUTO_RESTART_EN
            if (m_k >= m_resume) begin
                m_sl = 0; m_sr = 0; m_done = 1'b0;
            end
`endif
        end
        m_play = !m_done && (m_k >= m_resume);
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        L = 1'b0; R = 1'b0; L_edge = 1'b0; R_edge = 1'b0;
    endtask

    task automatic pulse_reset();
        idle_inputs();
        rst = 1'b1; tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst = 1'b1;
        tick(); tick();
        n_vec++; if (hex_l !== DIG0) begin n_bad++; $display("FAIL reset.hex_l got=%b exp=%b", hex_l, DIG0); end
        n_vec++; if (hex_r !== DIG0) begin n_bad++; $display("FAIL reset.hex_r got=%b exp=%b", hex_r, DIG0); end
        n_vec++; if (hex_stat !== DASH) begin n_bad++; $display("FAIL reset.hex_stat got=%b exp=%b", hex_stat, DASH); end
        n_vec++; if ({play_rst, match_over, winner} !== 4'b0000) begin
            n_bad++; $display("FAIL reset.flags got=%b exp=0000", {play_rst, match_over, winner});
        end
        rst = 1'b0;
        tick();
        n_vec++; if (dut_vec !== model_out()) begin n_bad++; $display("FAIL reset.model got=%h exp=%h", dut_vec, model_out()); end
    endtask

    task automatic test_left_point();
        L_edge = 1'b1; L = 1'b1; R = 1'b0;
        tick();
        idle_inputs();
        n_vec++; if (hex_l !== DIG1) begin n_bad++; $display("FAIL left_point.hex_l got=%b exp=%b", hex_l, DIG1); end
        n_vec++; if (winner !== 2'b01) begin n_bad++; $display("FAIL left_point.winner got=%b exp=01", winner); end
        n_vec++; if (hex_stat !== GL) begin n_bad++; $display("FAIL left_point.hex_stat got=%b exp=%b", hex_stat, GL); end
        n_vec++; if (play_rst !== 1'b1) begin n_bad++; $display("FAIL left_point.play_rst0 got=%b exp=1", play_rst); end
        for (int i = 1; i < HOLD; i++) begin
            tick();
            n_vec++; if (play_rst !== 1'b1) begin n_bad++; $display("FAIL left_point.hold cyc=%0d got=%b exp=1", i, play_rst); end
        end
        tick();
        n_vec++; if ({play_rst, winner, hex_stat} !== {1'b0, 2'b00, DASH}) begin
            n_bad++; $display("FAIL left_point.resume got=%b exp=%b", {play_rst, winner, hex_stat}, {1'b0, 2'b00, DASH});
        end
        n_vec++; if (dut_vec !== model_out()) begin n_bad++; $display("FAIL left_point.model got=%h exp=%h", dut_vec, model_out()); end
    endtask

    task automatic test_both_keys();
        pulse_reset();
        for (int i = 0; i < 10; i++) begin
            L_edge = 1'b1; L = 1'b1; R = 1'b1; R_edge = 1'($urandom_range(0, 1));
            tick();
            n_vec++; if ({hex_l, hex_r, play_rst} !== {DIG0, DIG0, 1'b0}) begin
                n_bad++; $display("FAIL both_keys cyc=%0d got=%b exp=%b", i, {hex_l, hex_r, play_rst}, {DIG0, DIG0, 1'b0});
            end
        end
        idle_inputs();
    endtask

    task automatic test_key_held();
        pulse_reset();
        L = 1'b1; L_edge = 1'b1; R = 1'b0;
        for (int i = 0; i <= HOLD; i++) begin
            tick();
            n_vec++; if (dut_vec !== model_out()) begin n_bad++; $display("FAIL key_held.model cyc=%0d got=%h exp=%h", i, dut_vec, model_out()); end
        end
        n_vec++; if (hex_l !== DIG1) begin n_bad++; $display("FAIL key_held.one_point got=%b exp=%b", hex_l, DIG1); end
        tick();
        n_vec++; if (hex_l !== DIG2) begin n_bad++; $display("FAIL key_held.next_round got=%b exp=%b", hex_l, DIG2); end
        idle_inputs();
        repeat (HOLD) tick();
    endtask

    task automatic test_rst_mid_round();
        pulse_reset();
        R = 1'b1; R_edge = 1'b1; L = 1'b0;
        tick();
        idle_inputs();
        tick();
        n_vec++; if (play_rst !== 1'b1) begin n_bad++; $display("FAIL rst_mid.in_round got=%b exp=1", play_rst); end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        n_vec++; if ({hex_l, hex_r, hex_stat, play_rst, match_over, winner} !== {DIG0, DIG0, DASH, 4'b0000}) begin
            n_bad++; $display("FAIL rst_mid.after got=%h exp=%h", dut_vec, {DIG0, DIG0, DASH, 4'b0000});
        end
    endtask

    task automatic test_match_right();
        pulse_reset();
        for (int rnd = 0; rnd < WIN; rnd++) begin
            R = 1'b1; R_edge = 1'b1; L = 1'b0;
            tick();
            idle_inputs();
            n_vec++; if (dut_vec !== model_out()) begin n_bad++; $display("FAIL match_right.model rnd=%0d got=%h exp=%h", rnd, dut_vec, model_out()); end
            if (rnd < WIN - 1) repeat (HOLD) tick();
        end
        n_vec++; if ({hex_r, match_over, winner, hex_stat} !== {DIG3, 1'b1, 2'b10, GR}) begin
            n_bad++; $display("FAIL match_right.done got=%b exp=%b", {hex_r, match_over, winner, hex_stat}, {DIG3, 1'b1, 2'b10, GR});
        end
        for (int i = 0; i < 12; i++) begin
            R = 1'b1; R_edge = 1'b1; L = 1'b0;
            tick();
            n_vec++; if (dut_vec !== model_out()) begin n_bad++; $display("FAIL match_right.after cyc=%0d got=%h exp=%h", i, dut_vec, model_out()); end
`ifndef MATCH_AUTO_RESTART_EN
            n_vec++; if (hex_r !== DIG3) begin n_bad++; $display("FAIL match_right.capped cyc=%0d got=%b exp=%b", i, hex_r, DIG3); end
`endif
        end
        idle_inputs();
    endtask

    task automatic test_auto_restart();
        int cnt;
        int exp_cnt;
        pulse_reset();
        for (int rnd = 0; rnd < WIN; rnd++) begin
            L = 1'b1; L_edge = 1'b1; R = 1'b0;
            tick();
            idle_inputs();
            if (rnd < WIN - 1) repeat (HOLD) tick();
        end
        cnt = match_over ? 1 : 0;
        for (int i = 0; i < 99 && cnt > 0; i++) begin
            tick();
            n_vec++; if (dut_vec !== model_out()) begin n_bad++; $display("FAIL auto_restart.model cyc=%0d got=%h exp=%h", i, dut_vec, model_out()); end
            if (!match_over) break;
            cnt++;
        end
`ifdef MATCH_AUTO_RESTART_EN
        exp_cnt = HOLD;
`else
        exp_cnt = 100;
`endif
        n_vec++; if (cnt !== exp_cnt) begin n_bad++; $display("FAIL auto_restart.duration got=%0d exp=%0d", cnt, exp_cnt); end
`ifdef MATCH_AUTO_RESTART_EN
        n_vec++; if ({hex_l, hex_r} !== {DIG0, DIG0}) begin n_bad++; $display("FAIL auto_restart.cleared got=%b exp=%b", {hex_l, hex_r}, {DIG0, DIG0}); end
`endif
    endtask

    task automatic test_random();
        pulse_reset();
        for (int i = 0; i < 800; i++) begin
            rst    = ($urandom_range(0, 69) == 0);
            L      = 1'($urandom_range(0, 1));
            R      = 1'($urandom_range(0, 1));
            L_edge = 1'($urandom_range(0, 1));
            R_edge = 1'($urandom_range(0, 1));
            tick();
            n_vec++; if (dut_vec !== model_out()) begin n_bad++; $display("FAIL random.model cyc=%0d got=%h exp=%h", i, dut_vec, model_out()); end
        end
        rst = 1'b0;
        idle_inputs();
    endtask

    initial begin
        rst = 1'b1;
        idle_inputs();
        test_reset();
        test_left_point();
        test_both_keys();
        test_key_held();
        test_rst_mid_round();
        test_match_right();
        test_auto_restart();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
